program_loader: RTL and testbench

- Byte-stream loader that writes a program image into the CPU's instruction memory. It is the writer side of the interface that the CPU fetches from.
- Receives bytes over a valid/ready handshake, parses a small framed image, assembles big-endian 32-bit words, and issues one-cycle write strobes at consecutive word addresses.
- Holds the CPU halted (cpu_run low) until a complete, checksum-verified image has been written.

---
 rtl/program_loader_if.sv | 33 +++
 rtl/program_loader.sv | 184 ++++++++++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus for the program loader.
// The master modport is the loader itself: it accepts bytes and drives the
// memory write port. The slave modport is the surrounding environment.
interface program_loader_if #(
  parameter int ADDR_W = 10
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Program loader: parses a framed byte stream (length, big-endian words,
// XOR checksum) and writes the words into instruction memory. The CPU is
// held halted until a complete, checksum-verified image has been written.
module program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpu_run,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code
);

  // One extra index bit so a full-capacity image (N = 2^ADDR_W) can be counted.
  localparam int          IDX_W    = ADDR_W + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;

  logic [15:0]       r_len;
  logic [7:0]        r_xor;
  logic [23:0]       r_asm;
  logic [1:0]        r_byteCnt;
  logic [IDX_W-1:0]  r_wordIdx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_errCode;

  logic              w_inReady;
  logic              w_xfer;
  logic              w_load;
  logic [15:0]       w_lenFull;
  logic              w_lenOverflow;
  logic              w_lenZero;
  logic              w_wordDone;
  logic              w_lastWord;
  logic              w_csumOk;
  logic [31:0]       w_word;

  // The assembly register only keeps the three most recent bytes; the
  // fourth comes straight from in_data when the word completes.
  assign w_inReady     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                         (r_state == S_DATA)   || (r_state == S_CHECK);
  assign w_xfer        = bus.in_valid && w_inReady;
  assign w_load        = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERROR));
  assign w_lenFull     = {r_len[15:8], bus.in_data};
  assign w_lenOverflow = {1'b0, w_lenFull} > CAPACITY;
  assign w_lenZero     = (w_lenFull == 16'd0);
  assign w_wordDone    = (r_byteCnt == 2'd3);
  assign w_lastWord    = (32'(r_wordIdx) + 32'd1) == 32'(r_len);
  assign w_csumOk      = (r_xor == bus.in_data);
  assign w_word        = {r_asm, bus.in_data};

  assign bus.in_ready   = w_inReady;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign err_code       = r_errCode;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    cpu_run     = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_stateNext = S_LEN_HI;
      end
      S_LEN_HI: begin
        busy = 1'b1;
        if (w_xfer) w_stateNext = S_LEN_LO;
      end
      S_LEN_LO: begin
        busy = 1'b1;
        if (w_xfer) begin
          if (w_lenOverflow)  w_stateNext = S_ERROR;
          else if (w_lenZero) w_stateNext = S_CHECK;
          else                w_stateNext = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (w_xfer && w_wordDone && w_lastWord) w_stateNext = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (w_xfer) w_stateNext = w_csumOk ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        cpu_run = 1'b1;
        done    = 1'b1;
        if (start) w_stateNext = S_LEN_HI;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) w_stateNext = S_LEN_HI;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Datapath: length capture, running checksum, word assembly and write strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_len     <= '0;
      r_xor     <= '0;
      r_asm     <= '0;
      r_byteCnt <= '0;
      r_wordIdx <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_errCode <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_load) begin
        r_xor     <= '0;
        r_asm     <= '0;
        r_byteCnt <= '0;
        r_wordIdx <= '0;
        r_errCode <= '0;
      end else if (w_xfer) begin
        case (r_state)
          S_LEN_HI: begin
            r_len[15:8] <= bus.in_data;
            r_xor       <= r_xor ^ bus.in_data;
          end
          S_LEN_LO: begin
            r_len[7:0] <= bus.in_data;
            r_xor      <= r_xor ^ bus.in_data;
            if (w_lenOverflow) r_errCode <= 2'b01;
          end
          S_DATA: begin
            r_xor     <= r_xor ^ bus.in_data;
            r_asm     <= w_word[23:0];
            r_byteCnt <= r_byteCnt + 2'd1;
            if (w_wordDone) begin
              r_we      <= 1'b1;
              r_wdata   <= w_word;
              r_addr    <= r_wordIdx[ADDR_W-1:0];
              r_wordIdx <= r_wordIdx + IDX_W'(1);
            end
          end
          S_CHECK: begin
            if (!w_csumOk) r_errCode <= 2'b10;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: streams hand-built frames and
// checks the memory writes and status flags against hand-computed values.
module tb_program_loader;

  localparam int ADDR_W = 10;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b1;
  logic       start = 1'b0;
  logic       cpu_run;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] wrAddrQ[$];
  logic [31:0]       wrDataQ[$];
  logic [7:0]        frame[$];

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .bus      (bus),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Log every memory write, sampled away from the active edge.
  always @(negedge CLK) begin
    if (bus.imem_we === 1'b1) begin
      wrAddrQ.push_back(bus.imem_addr);
      wrDataQ.push_back(bus.imem_wdata);
    end
  end

  function automatic logic [31:0] wrData(input int i);
    if (i < wrDataQ.size()) return wrDataQ[i];
    return 'x;
  endfunction

  function automatic logic [31:0] wrAddr(input int i);
    if (i < wrAddrQ.size()) return 32'(wrAddrQ[i]);
    return 'x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Send one byte; returns #1 after the accepting edge with in_valid dropped.
  task automatic applyStimulus(input logic [7:0] b, input bit gappy);
    int guard;
    for (int g = 0; g < 4 && gappy && ($urandom_range(1, 0) == 0); g++) begin
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 20) checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] f[$], input bit gappy);
    foreach (f[i]) applyStimulus(f[i], gappy);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic clearLog();
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state.
    #2 RST_N = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_imem_we",  32'(bus.imem_we),  32'd0);
    checkOutput("rst_busy",     32'(busy),         32'd0);
    checkOutput("rst_done",     32'(done),         32'd0);
    checkOutput("rst_error",    32'(error),        32'd0);
    checkOutput("rst_err_code", 32'(err_code),     32'd0);
    checkOutput("rst_cpu_run",  32'(cpu_run),      32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Two-word frame, back-to-back. Checksum: 00^02^20^08^00^05^8C^09^00^04 = AE.
    $display("[TB] two-word frame, back-to-back");
    pulseStart();
    clearLog();
    checkOutput("t1_busy",     32'(busy),         32'd1);
    checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd1);
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
              8'h8C, 8'h09, 8'h00, 8'h04, 8'hAE};
    sendFrame(frame, 1'b0);
    checkOutput("t1_wr_count", 32'(wrDataQ.size()), 32'd2);
    checkOutput("t1_addr0",    wrAddr(0),           32'd0);
    checkOutput("t1_data0",    wrData(0),           32'h20080005);
    checkOutput("t1_addr1",    wrAddr(1),           32'd1);
    checkOutput("t1_data1",    wrData(1),           32'h8C090004);
    checkOutput("t1_done",     32'(done),           32'd1);
    checkOutput("t1_cpu_run",  32'(cpu_run),        32'd1);
    checkOutput("t1_error",    32'(error),          32'd0);
    checkOutput("t1_busy_end", 32'(busy),           32'd0);

    // Same frame with random gaps, restarted from DONE.
    $display("[TB] two-word frame, gappy valid");
    pulseStart();
    clearLog();
    checkOutput("t2_done_clr", 32'(done),    32'd0);
    checkOutput("t2_run_clr",  32'(cpu_run), 32'd0);
    sendFrame(frame, 1'b1);
    checkOutput("t2_wr_count", 32'(wrDataQ.size()), 32'd2);
    checkOutput("t2_addr0",    wrAddr(0),           32'd0);
    checkOutput("t2_data0",    wrData(0),           32'h20080005);
    checkOutput("t2_addr1",    wrAddr(1),           32'd1);
    checkOutput("t2_data1",    wrData(1),           32'h8C090004);
    checkOutput("t2_done",     32'(done),           32'd1);
    checkOutput("t2_cpu_run",  32'(cpu_run),        32'd1);

    // Empty image.
    $display("[TB] empty image");
    pulseStart();
    clearLog();
    frame = '{8'h00, 8'h00, 8'h00};
    sendFrame(frame, 1'b0);
    checkOutput("t3_wr_count", 32'(wrDataQ.size()), 32'd0);
    checkOutput("t3_done",     32'(done),           32'd1);
    checkOutput("t3_cpu_run",  32'(cpu_run),        32'd1);

    // Bad checksum (correct value would be 01^DE^AD^BE^EF = 23).
    $display("[TB] checksum mismatch");
    pulseStart();
    clearLog();
    frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    sendFrame(frame, 1'b0);
    checkOutput("t4_wr_count", 32'(wrDataQ.size()), 32'd1);
    checkOutput("t4_addr0",    wrAddr(0),           32'd0);
    checkOutput("t4_data0",    wrData(0),           32'hDEADBEEF);
    checkOutput("t4_error",    32'(error),          32'd1);
    checkOutput("t4_err_code", 32'(err_code),       32'd2);
    checkOutput("t4_cpu_run",  32'(cpu_run),        32'd0);
    checkOutput("t4_done",     32'(done),           32'd0);
    checkOutput("t4_in_ready", 32'(bus.in_ready),   32'd0);

    // Length one past capacity.
    $display("[TB] length overflow");
    pulseStart();
    clearLog();
    checkOutput("t5_error_clr", 32'(error),    32'd0);
    checkOutput("t5_code_clr",  32'(err_code), 32'd0);
    frame = '{8'h04, 8'h01};
    sendFrame(frame, 1'b0);
    checkOutput("t5_error",    32'(error),          32'd1);
    checkOutput("t5_err_code", 32'(err_code),       32'd1);
    checkOutput("t5_in_ready", 32'(bus.in_ready),   32'd0);
    checkOutput("t5_cpu_run",  32'(cpu_run),        32'd0);
    @(posedge CLK); #1;
    checkOutput("t5_wr_count", 32'(wrDataQ.size()), 32'd0);

    // Full-capacity image: 1023 zero words then 12345678.
    // Checksum: 04^00^12^34^56^78 = 0C.
    $display("[TB] full-capacity image");
    pulseStart();
    clearLog();
    frame.delete();
    frame.push_back(8'h04);
    frame.push_back(8'h00);
    for (int i = 0; i < 1023 * 4; i++) frame.push_back(8'h00);
    frame.push_back(8'h12);
    frame.push_back(8'h34);
    frame.push_back(8'h56);
    frame.push_back(8'h78);
    frame.push_back(8'h0C);
    sendFrame(frame, 1'b0);
    checkOutput("t6_wr_count", 32'(wrDataQ.size()), 32'd1024);
    checkOutput("t6_addr0",    wrAddr(0),           32'd0);
    checkOutput("t6_data0",    wrData(0),           32'd0);
    checkOutput("t6_addr512",  wrAddr(512),         32'h200);
    checkOutput("t6_addr_last", wrAddr(1023),       32'h3FF);
    checkOutput("t6_data_last", wrData(1023),       32'h12345678);
    checkOutput("t6_done",     32'(done),           32'd1);
    checkOutput("t6_error",    32'(error),          32'd0);

    // Asynchronous reset mid-frame with a write pending, then a fresh load.
    $display("[TB] reset mid-frame");
    pulseStart();
    clearLog();
    frame = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    sendFrame(frame, 1'b0);
    checkOutput("t7_we_latency", 32'(bus.imem_we),   32'd1);
    checkOutput("t7_we_addr",    32'(bus.imem_addr), 32'd0);
    checkOutput("t7_we_data",    bus.imem_wdata,     32'h11223344);
    RST_N = 1'b0;
    #1;
    checkOutput("t7_rst_we",       32'(bus.imem_we),  32'd0);
    checkOutput("t7_rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t7_rst_busy",     32'(busy),         32'd0);
    checkOutput("t7_rst_done",     32'(done),         32'd0);
    checkOutput("t7_rst_cpu_run",  32'(cpu_run),      32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    checkOutput("t7_rst_wr_count", 32'(wrDataQ.size()), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checkOutput("t7_idle_busy", 32'(busy), 32'd0);
    // Checksum: 00^01^CA^FE^BA^BE = 31.
    pulseStart();
    clearLog();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'hCA, 1'b0);
    pulseStart();
    checkOutput("t7_start_ignored_busy", 32'(busy),         32'd1);
    checkOutput("t7_start_ignored_rdy",  32'(bus.in_ready), 32'd1);
    applyStimulus(8'hFE, 1'b0);
    applyStimulus(8'hBA, 1'b0);
    applyStimulus(8'hBE, 1'b0);
    applyStimulus(8'h31, 1'b0);
    checkOutput("t7_wr_count", 32'(wrDataQ.size()), 32'd1);
    checkOutput("t7_addr0",    wrAddr(0),           32'd0);
    checkOutput("t7_data0",    wrData(0),           32'hCAFEBABE);
    checkOutput("t7_done",     32'(done),           32'd1);
    checkOutput("t7_cpu_run",  32'(cpu_run),        32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
